// File: rtl/sine_request_arbiter_pkg.sv
// Shared defaults, tag record and pointer helper for the sine request arbiter.
// The tag carries the owner of each operation through the calculator latency.
package sine_request_arbiter_pkg;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_EXP_LEN      = 8;
    localparam int DEF_MANTISSA_LEN = 23;
    localparam int DEF_CALC_LATENCY = 2;

    // Wide enough for up to 256 requesters; the top compares the full field.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int rr_next(input int id, input int n);
        return (id == n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/sine_request_arbiter_if.sv
// Requester, calculator and response bundle of the sine request arbiter.
// slave is the arbiter side; master is the parent that owns requesters and calculator.
interface sine_request_arbiter_if
    import sine_request_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_EXP_LEN + DEF_MANTISSA_LEN + 1
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0][W-1:0] req_theta;
    logic [N_REQ-1:0]        req_sine_cosine;
    logic                    arb_hold;
    logic                    calc_enable;
    logic [W-1:0]            calc_theta;
    logic                    calc_sine_cosine;
    logic [W-1:0]            calc_out_value;
    logic [N_REQ-1:0]        resp_valid;
    logic [W-1:0]            resp_value;
    logic [ID_W-1:0]         resp_id;
    logic                    idle;

    modport slave (
        input  req_valid, req_theta, req_sine_cosine, arb_hold, calc_out_value,
        output req_ready, calc_enable, calc_theta, calc_sine_cosine,
        output resp_valid, resp_value, resp_id, idle
    );

    modport master (
        output req_valid, req_theta, req_sine_cosine, arb_hold, calc_out_value,
        input  req_ready, calc_enable, calc_theta, calc_sine_cosine,
        input  resp_valid, resp_value, resp_id, idle
    );

endinterface

// File: rtl/sine_request_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first request at or after i_ptr.
// The request vector is doubled so a lowest-set-bit scan naturally wraps.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant
);
    localparam logic [2*N_REQ-1:0] ONE = {{(2*N_REQ-1){1'b0}}, 1'b1};

    logic [2*N_REQ-1:0] w_mask;
    logic [2*N_REQ-1:0] w_cand;
    logic [2*N_REQ-1:0] w_first;

    genvar gi;
    generate
        for (gi = 0; gi < 2 * N_REQ; gi++) begin : g_mask
            assign w_mask[gi] = (gi >= int'(i_ptr));
        end
    endgenerate

    assign w_cand  = {i_req, i_req} & w_mask;
    assign w_first = w_cand & ~(w_cand - ONE);
    assign o_grant = w_first[N_REQ-1:0] | w_first[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/sine_request_arbiter.sv
// Shares one pipelined sine calculator among N_REQ requesters with round-robin
// grants and a tag pipeline that routes each result back to its owner.
module sine_request_arbiter
    import sine_request_arbiter_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int EXP_LEN      = DEF_EXP_LEN,
    parameter int MANTISSA_LEN = DEF_MANTISSA_LEN,
    parameter int CALC_LATENCY = DEF_CALC_LATENCY
) (
    input  logic clk,
    input  logic rst,
    sine_request_arbiter_if.slave bus
);
    localparam int W    = EXP_LEN + MANTISSA_LEN + 1;
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IF_W = $clog2(CALC_LATENCY + 1);

    logic [ID_W-1:0]  r_ptr;
    tag_t             r_tag [CALC_LATENCY];
    logic [IF_W-1:0]  r_in_flight;

    logic [N_REQ-1:0] w_req_eff;
    logic [N_REQ-1:0] w_grant;
    logic             w_grant_any;
    logic [ID_W-1:0]  w_grant_id;
    tag_t             w_tail;
    logic             w_resp_fire;
    logic [N_REQ-1:0] w_resp_valid;

    // Hold and reset gate the requests so no grant can be produced at all.
    assign w_req_eff = (rst || bus.arb_hold) ? '0 : bus.req_valid;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (ID_W)
    ) u_picker (
        .i_req   (w_req_eff),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign w_grant_any = |w_grant;

    always_comb begin
        w_grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_grant_id = ID_W'(k);
            end
        end
    end

    assign bus.req_ready        = w_grant;
    assign bus.calc_enable      = w_grant_any;
    assign bus.calc_theta       = w_grant_any ? bus.req_theta[w_grant_id] : '0;
    assign bus.calc_sine_cosine = w_grant_any ? bus.req_sine_cosine[w_grant_id] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            for (int k = 0; k < CALC_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            if (w_grant_any) begin
                r_ptr <= ID_W'(rr_next(int'(w_grant_id), N_REQ));
            end
            r_tag[0].valid <= w_grant_any;
            r_tag[0].id    <= w_grant_any ? TAG_ID_W'(w_grant_id) : '0;
            for (int k = 1; k < CALC_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // The tail tag lines up with calc_out_value for the operation it describes.
    assign w_tail      = r_tag[CALC_LATENCY-1];
    assign w_resp_fire = w_tail.valid && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_resp
            assign w_resp_valid[gi] = w_resp_fire && (w_tail.id == TAG_ID_W'(gi));
        end
    endgenerate

    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_id    = w_resp_fire ? w_tail.id[ID_W-1:0] : '0;
    assign bus.resp_value = w_resp_fire ? bus.calc_out_value : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_flight <= '0;
        end else begin
            case ({w_grant_any, w_resp_fire})
                2'b10:   r_in_flight <= r_in_flight + IF_W'(1);
                2'b01:   r_in_flight <= r_in_flight - IF_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign bus.idle = rst || ((r_in_flight == '0) && !w_grant_any);

endmodule

// File: tb/tb_sine_request_arbiter.sv
// Directed vector table plus randomized scoreboard run for sine_request_arbiter,
// with a simple pipelined stand-in for the sine calculator.
module tb_sine_request_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sine_request_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    sine_request_arbiter #(
        .N_REQ        (N),
        .EXP_LEN      (8),
        .MANTISSA_LEN (23),
        .CALC_LATENCY (LAT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] calc_fn(input logic [W-1:0] t, input logic s);
        return {t[W-2:0], s} ^ 32'h5A5A_0F0F;
    endfunction

    // Calculator stand-in: result of the operand sampled LAT edges earlier.
    logic [W-1:0] cpipe [LAT];
    always @(posedge clk) begin
        cpipe[0] <= calc_fn(bus.calc_theta, bus.calc_sine_cosine);
        for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
    end
    assign bus.calc_out_value = cpipe[LAT-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] theta_of(input int i);
        return 32'h3E00_0000 + W'(i) * 32'h0080_0000;
    endfunction

    typedef struct {
        logic       rst;
        logic       hold;
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [3:0] exp_resp;
        logic       exp_idle;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic h, input logic [3:0] v,
                       input logic [3:0] er, input logic [3:0] ep, input logic ei);
        vec_t x;
        x.rst = r; x.hold = h; x.valid = v;
        x.exp_ready = er; x.exp_resp = ep; x.exp_idle = ei;
        vecs.push_back(x);
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = 0;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    typedef struct {
        int           id;
        logic [W-1:0] value;
        int           due;
    } pend_t;

    initial begin
        pend_t        q[$];
        int           ptr;
        int           cyc;
        int           grant;
        int           n_seen;
        int           n_expect;
        logic         r, h;
        logic [3:0]   v;
        logic [3:0]   exp_ready, exp_resp;
        logic [1:0]   exp_id;
        logic [W-1:0] exp_theta, exp_value;
        logic         exp_sc, exp_idle;

        rst = 1'b1;
        bus.arb_hold = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_theta[i] = theta_of(i);
            bus.req_sine_cosine[i] = 1'(i % 2);
        end

        // Single request to 2
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 0, 4'b0100, 4'b0100, 4'b0000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0100, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        // All four valid for 8 cycles from reset
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 0, 4'b1111, 4'b0001, 4'b0000, 0);
        add(0, 0, 4'b1111, 4'b0010, 4'b0000, 0);
        add(0, 0, 4'b1111, 4'b0100, 4'b0001, 0);
        add(0, 0, 4'b1111, 4'b1000, 4'b0010, 0);
        add(0, 0, 4'b1111, 4'b0001, 4'b0100, 0);
        add(0, 0, 4'b1111, 4'b0010, 4'b1000, 0);
        add(0, 0, 4'b1111, 4'b0100, 4'b0001, 0);
        add(0, 0, 4'b1111, 4'b1000, 4'b0010, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0100, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b1000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        // Hold with two operations in flight
        add(0, 0, 4'b1111, 4'b0001, 4'b0000, 0);
        add(0, 0, 4'b1111, 4'b0010, 4'b0000, 0);
        add(0, 1, 4'b1111, 4'b0000, 4'b0001, 0);
        add(0, 1, 4'b1111, 4'b0000, 4'b0010, 0);
        add(0, 1, 4'b1111, 4'b0000, 4'b0000, 1);
        // Reset one cycle after a grant to 1 (pointer was 2, wraps to 1)
        add(0, 0, 4'b0010, 4'b0010, 4'b0000, 0);
        add(1, 0, 4'b1111, 4'b0000, 4'b0000, 1);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 0, 4'b1111, 4'b0001, 4'b0000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0001, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        // Only 3 valid: pointer wraps past 3 and 3 wins again
        add(0, 0, 4'b1000, 4'b1000, 4'b0000, 0);
        add(0, 0, 4'b1000, 4'b1000, 4'b0000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b1000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b1000, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 1);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst = vecs[n].rst;
            bus.arb_hold = vecs[n].hold;
            bus.req_valid = vecs[n].valid;
            #1;
            exp_ready = vecs[n].exp_ready;
            exp_resp  = vecs[n].exp_resp;
            exp_id    = 2'(onehot_idx(exp_resp));
            exp_theta = (exp_ready != 0) ? theta_of(onehot_idx(exp_ready)) : '0;
            exp_sc    = (exp_ready != 0) ? 1'(onehot_idx(exp_ready) % 2) : 1'b0;
            exp_value = (exp_resp != 0) ? calc_fn(theta_of(exp_id), 1'(exp_id % 2)) : '0;
            chk($sformatf("vec%0d req_ready", n), W'(bus.req_ready), W'(exp_ready));
            chk($sformatf("vec%0d calc_enable", n), W'(bus.calc_enable), W'(exp_ready != 0));
            chk($sformatf("vec%0d calc_theta", n), bus.calc_theta, exp_theta);
            chk($sformatf("vec%0d calc_sine_cosine", n), W'(bus.calc_sine_cosine), W'(exp_sc));
            chk($sformatf("vec%0d resp_valid", n), W'(bus.resp_valid), W'(exp_resp));
            chk($sformatf("vec%0d resp_id", n), W'(bus.resp_id), W'(exp_id));
            chk($sformatf("vec%0d resp_value", n), bus.resp_value, exp_value);
            chk($sformatf("vec%0d idle", n), W'(bus.idle), W'(vecs[n].exp_idle));
            $display("vec %0d rst=%0b hold=%0b valid=%b ready=%b resp=%b id=%0d idle=%0b",
                     n, rst, bus.arb_hold, bus.req_valid, bus.req_ready,
                     bus.resp_valid, bus.resp_id, bus.idle);
        end

        // Randomized run against a queue-based model of the arbitration rules.
        ptr = 0; cyc = 0; n_seen = 0; n_expect = 0;
        for (int c = 0; c < 10000 + LAT + 2; c++) begin
            @(negedge clk);
            if (c == 0) r = 1'b1;
            else if (c >= 10000) r = 1'b0;
            else r = ($urandom_range(0, 299) == 0);
            h = (c < 10000) && ($urandom_range(0, 3) == 0);
            v = (c < 10000) ? 4'($urandom & ($urandom_range(0, 1) ? 32'hF : $urandom)) : 4'b0;
            rst = r;
            bus.arb_hold = h;
            bus.req_valid = v;
            for (int i = 0; i < N; i++) begin
                bus.req_theta[i] = $urandom;
                bus.req_sine_cosine[i] = 1'($urandom_range(0, 1));
            end
            #1;
            grant = -1;
            if (!r && !h) begin
                for (int k = 0; k < N; k++) begin
                    if (grant < 0 && v[(ptr + k) % N]) grant = (ptr + k) % N;
                end
            end
            exp_ready = (grant >= 0) ? 4'(1 << grant) : 4'b0;
            exp_theta = (grant >= 0) ? bus.req_theta[grant] : '0;
            exp_sc    = (grant >= 0) ? bus.req_sine_cosine[grant] : 1'b0;
            exp_resp  = 4'b0; exp_id = 2'd0; exp_value = '0;
            if (!r && q.size() > 0 && q[0].due == cyc) begin
                exp_resp  = 4'(1 << q[0].id);
                exp_id    = 2'(q[0].id);
                exp_value = q[0].value;
            end
            exp_idle = r || (q.size() == 0 && grant < 0);
            chk("rnd req_ready", W'(bus.req_ready), W'(exp_ready));
            chk("rnd calc_enable", W'(bus.calc_enable), W'(grant >= 0));
            chk("rnd calc_theta", bus.calc_theta, exp_theta);
            chk("rnd calc_sine_cosine", W'(bus.calc_sine_cosine), W'(exp_sc));
            chk("rnd resp_valid", W'(bus.resp_valid), W'(exp_resp));
            chk("rnd resp_id", W'(bus.resp_id), W'(exp_id));
            chk("rnd resp_value", bus.resp_value, exp_value);
            chk("rnd idle", W'(bus.idle), W'(exp_idle));
            if (bus.resp_valid != 0) n_seen++;
            if (r) begin
                q.delete();
                ptr = 0;
            end else begin
                if (exp_resp != 0) begin
                    void'(q.pop_front());
                    n_expect++;
                end
                if (grant >= 0) begin
                    pend_t p;
                    p.id = grant;
                    p.value = calc_fn(exp_theta, exp_sc);
                    p.due = cyc + LAT;
                    q.push_back(p);
                    ptr = (grant + 1) % N;
                end
            end
            cyc++;
            if (c % 1000 == 999)
                $display("random block ending cycle %0d: responses seen=%0d expected=%0d",
                         c, n_seen, n_expect);
        end
        chk("rnd response count", W'(n_seen), W'(n_expect));
        chk("rnd drained", W'(bus.idle), W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
